memory_arbiter: RTL
===================

// Module: memory_arbiter
// PURPOSE
//   N-channel arbiter that replaces the fixed 2:1 memory_mux in front of memory_unit.
//   Requesters are the MTU, the NEM and future units such as GC or DMA. Each raises a request; the arbiter grants one channel at a time and drives one memory_unit transaction (func/execute/address/write_data).
//   It returns read_data and a one-cycle done pulse to the granted channel.
//   Adds round-robin or fixed-priority selection and a per-channel lock for multi-access sequences, which the select-line mux lacks.
// PARAMETERS
//   N_CH      4   number of requesting channels (2..8)
//   ADDR_W    10  memory address width (matches memory_addr_width)
//   DATA_W    64  memory word width (matches memory_data_width)
//   FUNC_W    2   memory function code width
//   FIXED_PRI 0   0 = round-robin; 1 = fixed priority, lowest index wins
// PORTS
//   clk            in   1             system clock, all logic on posedge
//   rst            in   1             synchronous reset, active-high
//   ch_req         in   N_CH          per-channel request; hold until that channel's ch_done
//   ch_lock        in   N_CH          keep grant after done while ch_req stays high
//   ch_func        in   N_CH*FUNC_W   per-channel func, channel i at [i*FUNC_W +: FUNC_W]
//   ch_address     in   N_CH*ADDR_W   per-channel address, packed the same way
//   ch_write_data  in   N_CH*DATA_W   per-channel write data, packed the same way
//   ch_grant       out  N_CH          one-hot: channel that owns memory
//   ch_done        out  N_CH          one-hot, 1-cycle pulse when the transaction completes
//   ch_read_data   out  DATA_W        read_data captured at completion; held until next completion
//   mem_ready      in   1             memory_unit is_ready (1 = idle/complete)
//   mem_read_data  in   DATA_W        memory_unit read_data
//   mem_execute    out  1             memory_unit execute
//   mem_func       out  FUNC_W        memory_unit func
//   mem_address    out  ADDR_W        memory_unit address
//   mem_write_data out  DATA_W        memory_unit write_data
//   busy           out  1             high in any state other than IDLE
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0, lock_owner=none. All outputs 0, including ch_read_data.
//   FSM states are IDLE, ISSUE and BUSY. All outputs are registered.
//   IDLE:
//   - Stays in IDLE while no ch_req is high or mem_ready=0.
//   - Otherwise picks winner W and latches W's func, address and write_data into mem_* registers.
//   - Sets ch_grant[W]=1 and moves to ISSUE the next cycle.
//   Selection rules:
//   - Round-robin: first requesting index at or above rr_ptr, wrapping modulo N_CH.
//   - Fixed priority: lowest requesting index.
//   ISSUE: mem_execute=1. Holds until mem_ready=0 (accepted), then mem_execute=0 and moves to BUSY.
//   BUSY: when mem_ready=1, captures ch_read_data<=mem_read_data and pulses ch_done[W] for exactly 1 cycle.
//   After BUSY, round-robin sets rr_ptr<=(W+1) mod N_CH.
//   After BUSY, if ch_lock[W] and ch_req[W]:
//   - ch_grant[W] stays high and the new W fields are latched.
//   - FSM goes directly to ISSUE; other requests are not considered. rr_ptr is not advanced while locked.
//   After BUSY, if not locked: ch_grant<=0 and FSM returns to IDLE.
//   Grant-to-memory latency: 1 cycle from IDLE sampling a request to mem_execute=1.
//   Back-to-back transactions on different channels need 1 IDLE cycle between them.
//   A channel that drops ch_req while granted has no effect on the current transaction. It completes and ch_done still pulses.
//   Request changes on non-granted channels never disturb mem_* outputs.
//   Simultaneous requests from all channels with rr_ptr=N_CH-1: channel N_CH-1 is granted, then 0, 1, ...
//   Reset mid-transaction:
//   - Returns to IDLE next cycle, clears grant, mem_execute and pointers; no ch_done.
//   - The memory side is reset by the same rst.
//   Only one bit of ch_grant or ch_done is ever set.
//   ch_done is never asserted in the same cycle as mem_execute.
// TESTING
//   1 Reset: rst=1 for 2 cycles -> all outputs 0, busy=0.
//   2 Single request on ch2 (func=1 read, addr=0x05, mem returns 0xABCD):
//     -> mem_execute 1 cycle after req, mem_address=0x05, ch_done=4'b0100, ch_read_data=0xABCD.
//   3 Round-robin, ch_req=4'b1111 held:
//     -> grant order 0,1,2,3,0 across five transactions.
//     FIXED_PRI=1 with the same stimulus -> ch0 granted every time.
//   4 Lock: ch1 with ch_lock=1 makes three writes while ch0 and ch3 request:
//     -> ch1 gets 3 consecutive done pulses with no IDLE cycle, then ch3 (rr_ptr=2) is granted.
//   5 Reset asserted in BUSY -> next cycle ch_grant=0, mem_execute=0, no ch_done.
//     A request after reset is served from rr_ptr=0.
//   6 Integration: ch0=MTU, ch1=NEM with nested_increment.hex -> traversal finished, same final memory image as the memory_mux build.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Bundle of the requester-side and memory-side signals around memory_arbiter.
// The arbiter uses the slave modport; requesters and memory_unit sit on the master side.
interface memory_arbiter_if #(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int FUNC_W = 2
);
    logic [N_CH-1:0]        ch_req;
    logic [N_CH-1:0]        ch_lock;
    logic [N_CH*FUNC_W-1:0] ch_func;
    logic [N_CH*ADDR_W-1:0] ch_address;
    logic [N_CH*DATA_W-1:0] ch_write_data;
    logic [N_CH-1:0]        ch_grant;
    logic [N_CH-1:0]        ch_done;
    logic [DATA_W-1:0]      ch_read_data;
    logic                   mem_ready;
    logic [DATA_W-1:0]      mem_read_data;
    logic                   mem_execute;
    logic [FUNC_W-1:0]      mem_func;
    logic [ADDR_W-1:0]      mem_address;
    logic [DATA_W-1:0]      mem_write_data;
    logic                   busy;

    modport slave (
        input  ch_req, ch_lock, ch_func, ch_address, ch_write_data,
        input  mem_ready, mem_read_data,
        output ch_grant, ch_done, ch_read_data,
        output mem_execute, mem_func, mem_address, mem_write_data, busy
    );

    modport master (
        output ch_req, ch_lock, ch_func, ch_address, ch_write_data,
        output mem_ready, mem_read_data,
        input  ch_grant, ch_done, ch_read_data,
        input  mem_execute, mem_func, mem_address, mem_write_data, busy
    );
endinterface

// File: rtl/memory_arbiter.sv
// N-channel arbiter in front of memory_unit: round-robin or fixed-priority grant,
// one memory transaction at a time, optional per-channel lock for multi-access runs.
module memory_arbiter #(
    parameter int N_CH      = 4,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 64,
    parameter int FUNC_W    = 2,
    parameter int FIXED_PRI = 0
) (
    input  logic             clk,
    input  logic             rst,
    memory_arbiter_if.slave  bus
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic [N_CH-1:0]   done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              exec_q, exec_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;

    logic [FUNC_W-1:0] func_arr  [N_CH];
    logic [ADDR_W-1:0] addr_arr  [N_CH];
    logic [DATA_W-1:0] wdata_arr [N_CH];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign func_arr[gi]  = bus.ch_func[gi*FUNC_W +: FUNC_W];
            assign addr_arr[gi]  = bus.ch_address[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = bus.ch_write_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Winner search: scan N_CH candidates starting at rr_ptr (or 0 for fixed priority).
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            cand = (FIXED_PRI != 0) ? IDX_W'(k) : IDX_W'((int'(rr_ptr_q) + k) % N_CH);
            if (!found && bus.ch_req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    logic [IDX_W-1:0] sel;
    assign sel = (state_q == BUSY) ? owner_q : win;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        done_d   = '0;
        rdata_d  = rdata_q;
        exec_d   = exec_q;
        func_d   = func_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (found && bus.mem_ready) begin
                    state_d = ISSUE;
                    owner_d = win;
                    grant_d = N_CH'(1) << win;
                    exec_d  = 1'b1;
                    func_d  = func_arr[sel];
                    addr_d  = addr_arr[sel];
                    wdata_d = wdata_arr[sel];
                end
            end
            ISSUE: begin
                if (exec_q && !bus.mem_ready) begin
                    exec_d  = 1'b0;
                    state_d = BUSY;
                end else if (bus.mem_ready) begin
                    exec_d = 1'b1;
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    done_d  = N_CH'(1) << owner_q;
                    rdata_d = bus.mem_read_data;
                    if (bus.ch_lock[owner_q] && bus.ch_req[owner_q]) begin
                        // Locked follow-on: execute is raised one cycle later so it never
                        // coincides with this done pulse.
                        state_d = ISSUE;
                        func_d  = func_arr[sel];
                        addr_d  = addr_arr[sel];
                        wdata_d = wdata_arr[sel];
                    end else begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = IDX_W'((int'(owner_q) + 1) % N_CH);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            exec_q   <= 1'b0;
            func_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            exec_q   <= exec_d;
            func_q   <= func_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.ch_grant       = grant_q;
    assign bus.ch_done        = done_q;
    assign bus.ch_read_data   = rdata_q;
    assign bus.mem_execute    = exec_q;
    assign bus.mem_func       = func_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.busy           = busy_q;
endmodule
